// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command sequencer for an external bank of JK flip-flops.
// Accepts one command at a time and turns it into registered J/K drive vectors.
// After each drive step it waits for the bank to settle, then reads q back.
// The readback is compared with the value that step should have produced.
module jk_bank_seq #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [7:0]       cmd_count,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_SET    = 3'b010;
  localparam logic [2:0] OP_TOGGLE = 3'b011;
  localparam logic [2:0] OP_LOAD   = 3'b100;
  localparam logic [2:0] OP_INC    = 3'b101;
  localparam logic [2:0] OP_DEC    = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  localparam logic [WIDTH-1:0] ALL1      = '1;
  localparam logic [3:0]       WAIT_LAST = 4'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       count_q, count_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [3:0]       wait_q, wait_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;

  logic [2:0]       drv_op;
  logic [WIDTH-1:0] drv_data;
  logic [WIDTH-1:0] drv_j, drv_k, drv_exp;
  logic [WIDTH-1:0] inc_val, dec_val;

  assign inc_val = q_in + WIDTH'(1);
  assign dec_val = q_in - WIDTH'(1);

  // Drive vectors and expected readback for the next APPLY, computed from the live q_in
  always_comb begin
    drv_op   = (state_q == S_IDLE) ? cmd_op : op_q;
    drv_data = (state_q == S_IDLE) ? cmd_data : data_q;
    drv_j    = '0;
    drv_k    = '0;
    drv_exp  = '0;
    case (drv_op)
      OP_CLEAR: begin
        drv_k   = ALL1;
        drv_exp = '0;
      end
      OP_SET: begin
        drv_j   = ALL1;
        drv_exp = ALL1;
      end
      OP_TOGGLE: begin
        drv_j   = drv_data;
        drv_k   = drv_data;
        drv_exp = q_in ^ drv_data;
      end
      OP_LOAD: begin
        drv_j   = drv_data;
        drv_k   = ~drv_data;
        drv_exp = drv_data;
      end
      OP_INC: begin
        drv_j   = q_in ^ inc_val;
        drv_k   = q_in ^ inc_val;
        drv_exp = inc_val;
      end
      OP_DEC: begin
        drv_j   = q_in ^ dec_val;
        drv_k   = q_in ^ dec_val;
        drv_exp = dec_val;
      end
      default: begin
        drv_j   = '0;
        drv_k   = '0;
        drv_exp = '0;
      end
    endcase
  end

  // Next-state logic; j/k default to zero so they are only nonzero during APPLY
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    count_d  = count_q;
    exp_d    = exp_q;
    wait_d   = wait_q;
    err_d    = err_q;
    result_d = result_q;
    j_d      = '0;
    k_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          count_d = cmd_count;
          err_d   = 1'b0;
          case (cmd_op)
            OP_NOP: state_d = S_DONE;
            OP_RSVD: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
            OP_INC, OP_DEC: begin
              if (cmd_count == 8'd0) begin
                state_d = S_DONE;
              end else begin
                state_d = S_APPLY;
                j_d     = drv_j;
                k_d     = drv_k;
                exp_d   = drv_exp;
              end
            end
            default: begin
              state_d = S_APPLY;
              j_d     = drv_j;
              k_d     = drv_k;
              exp_d   = drv_exp;
            end
          endcase
        end
      end
      S_APPLY: begin
        state_d = S_WAIT;
        wait_d  = WAIT_LAST;
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_CHECK: begin
        result_d = q_in;
        if (q_in != exp_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (((op_q == OP_INC) || (op_q == OP_DEC)) && (count_q > 8'd1)) begin
          count_d = count_q - 8'd1;
          state_d = S_APPLY;
          j_d     = drv_j;
          k_d     = drv_k;
          exp_d   = drv_exp;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      data_q   <= '0;
      count_q  <= 8'd0;
      exp_q    <= '0;
      wait_q   <= 4'd0;
      j_q      <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      wait_q   <= wait_d;
      j_q      <= j_d;
      k_q      <= k_d;
      err_q    <= err_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign j_out     = j_q;
  assign k_out     = k_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign result    = result_q;

endmodule

// File: tb/tb_jk_bank_seq.sv
// tb_jk_bank_seq: bench for jk_bank_seq with a behavioural JK bank and a command-level reference model.
module tb_jk_bank_seq;

  localparam int W = 4;
  localparam int S = 1;
  localparam int P = 2 + S;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [7:0]   cmd_count;
  logic [W-1:0] q_in;
  logic [W-1:0] j_out, k_out;
  logic         busy, done, err;
  logic [W-1:0] result;

  logic [W-1:0] bank_q = '0;
  logic         stuck = 1'b0;

  logic [W-1:0] model_q = '0;
  logic [W-1:0] model_result = '0;

  int n_vec = 0;
  int n_err = 0;

  jk_bank_seq #(.WIDTH(W), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .q_in(q_in),
    .j_out(j_out), .k_out(k_out), .busy(busy), .done(done), .err(err), .result(result)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j, input logic [W-1:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  // The external JK bank, optionally seen through a stuck-at-zero fault
  always @(posedge clk) bank_q <= jk_next(bank_q, j_out, k_out);
  assign q_in = stuck ? '0 : bank_q;

  // Issue one command, predict its whole trace from the model, and check it cycle by cycle
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data, input logic [7:0] count, input bit hold);
    logic [2*W-1:0] pairs[$];
    logic [2*W-1:0] exp_jk;
    logic [W-1:0]   seen, target, j, k;
    logic [W-1:0]   exp_res;
    int             steps, total, lat, c;
    bit             exp_err, finished;
    pairs.delete();
    exp_err = 1'b0;
    exp_res = model_result;
    steps   = 0;
    total   = 0;
    if (op == 3'b111) exp_err = 1'b1;
    else if (op == 3'b000) total = 0;
    else if (op == 3'b101 || op == 3'b110) total = int'(count);
    else total = 1;
    for (int s = 0; s < total; s++) begin
      seen = stuck ? '0 : model_q;
      case (op)
        3'b001: begin target = '0;          j = '0;   k = '1;    end
        3'b010: begin target = '1;          j = '1;   k = '0;    end
        3'b011: begin target = seen ^ data; j = data; k = data;  end
        3'b100: begin target = data;        j = data; k = ~data; end
        3'b101: begin target = seen + 1'b1; j = seen ^ target; k = j; end
        default: begin target = seen - 1'b1; j = seen ^ target; k = j; end
      endcase
      pairs.push_back({j, k});
      steps++;
      model_q = jk_next(model_q, j, k);
      seen    = stuck ? '0 : model_q;
      exp_res = seen;
      if (seen != target) begin
        exp_err = 1'b1;
        break;
      end
    end
    lat = steps * P;

    c = 0;
    while (cmd_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ready_wait: cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = hold;
    cmd_op    = 3'($urandom);
    cmd_data  = W'($urandom);
    cmd_count = 8'($urandom);

    finished = 1'b0;
    c = 0;
    while (!finished && c <= lat + 20) begin
      exp_jk = (c < lat && (c % P) == 0) ? pairs[c / P] : '0;
      n_vec++;
      if ({j_out, k_out} !== exp_jk) begin
        n_err++;
        $display("[TB] FAIL jk op=%b cyc=%0d: j=%b k=%b expected j=%b k=%b", op, c, j_out, k_out, exp_jk[2*W-1:W], exp_jk[W-1:0]);
      end
      if (done === 1'b1) begin
        finished = 1'b1;
        n_vec++;
        if (c != lat) begin
          n_err++;
          $display("[TB] FAIL latency op=%b: done at %0d expected %0d", op, c, lat);
        end
      end else begin
        n_vec++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL busy op=%b cyc=%0d: busy=%b ready=%b expected 1/0", op, c, busy, cmd_ready);
        end
        @(negedge clk);
        c++;
      end
    end
    n_vec++;
    if (!finished) begin
      n_err++;
      $display("[TB] FAIL timeout op=%b: no done within %0d cycles", op, lat + 20);
    end
    n_vec++;
    if (err !== exp_err) begin
      n_err++;
      $display("[TB] FAIL err op=%b: err=%b expected %b", op, err, exp_err);
    end
    n_vec++;
    if (result !== exp_res) begin
      n_err++;
      $display("[TB] FAIL result op=%b: result=%b expected %b", op, result, exp_res);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL idle_after op=%b: ready=%b busy=%b done=%b expected 1/0/0", op, cmd_ready, busy, done);
    end
    model_result = exp_res;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = '0;
    cmd_count = 8'd0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({cmd_ready, busy, done, err} !== 4'b0000 || result !== '0 || j_out !== '0 || k_out !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_state: ready=%b busy=%b done=%b err=%b result=%b j=%b k=%b expected all 0",
               cmd_ready, busy, done, err, result, j_out, k_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_release: cmd_ready=%b expected 1", cmd_ready);
    end
    model_result = '0;
  endtask

  task automatic test_clear();
    run_cmd(3'b001, 4'b0000, 8'd0, 1'b0);
    n_vec++;
    if (result !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL clear_result: result=%b expected 0000", result);
    end
  endtask

  task automatic test_load_toggle();
    run_cmd(3'b100, 4'b1010, 8'd0, 1'b0);
    n_vec++;
    if (result !== 4'b1010) begin
      n_err++;
      $display("[TB] FAIL load_result: result=%b expected 1010", result);
    end
    run_cmd(3'b011, 4'b0110, 8'd0, 1'b1);
    n_vec++;
    if (result !== 4'b1100) begin
      n_err++;
      $display("[TB] FAIL toggle_result: result=%b expected 1100", result);
    end
  endtask

  task automatic test_inc_wrap();
    run_cmd(3'b100, 4'b1110, 8'd0, 1'b0);
    run_cmd(3'b101, 4'b0000, 8'd3, 1'b1);
    n_vec++;
    if (result !== 4'b0001 || err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL inc_wrap: result=%b err=%b expected 0001/0", result, err);
    end
  endtask

  task automatic test_dec_reserved();
    run_cmd(3'b100, 4'b0000, 8'd0, 1'b0);
    run_cmd(3'b110, 4'b0000, 8'd1, 1'b0);
    n_vec++;
    if (result !== 4'b1111) begin
      n_err++;
      $display("[TB] FAIL dec_wrap: result=%b expected 1111", result);
    end
    run_cmd(3'b111, 4'b0101, 8'd0, 1'b0);
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reserved_err: err=%b expected 1", err);
    end
    run_cmd(3'b000, 4'b0000, 8'd0, 1'b0);
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL nop_clears_err: err=%b expected 0", err);
    end
  endtask

  task automatic test_fault();
    run_cmd(3'b100, 4'b0000, 8'd0, 1'b0);
    stuck = 1'b1;
    run_cmd(3'b101, 4'b0000, 8'd5, 1'b0);
    stuck = 1'b0;
    n_vec++;
    if (err !== 1'b1 || result !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL stuck_fault: err=%b result=%b expected 1/0000", err, result);
    end
  endtask

  task automatic test_reset_mid();
    while (cmd_ready !== 1'b1) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'b101;
    cmd_data  = '0;
    cmd_count = 8'd4;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 3'b010;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    model_q = model_q + 1'b1;
    @(negedge clk);
    n_vec++;
    if (j_out !== '0 || k_out !== '0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_mid: j=%b k=%b busy=%b done=%b ready=%b expected 0", j_out, k_out, busy, done, cmd_ready);
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_mid_release: ready=%b done=%b busy=%b result=%b expected 1/0/0/0000", cmd_ready, done, busy, result);
    end
    model_result = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_cmd(3'($urandom_range(0, 7)), W'($urandom), 8'($urandom_range(0, 5)), 1'($urandom));
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_clear();
    test_load_toggle();
    test_inc_wrap();
    test_dec_reserved();
    test_fault();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
